// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// the helper that maps a state onto the debounced "pressed" level.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } dbnc_state_e;

  // The button counts as held while it is accepted-pressed or only tentatively released.
  function automatic logic state_is_pressed(input dbnc_state_e s);
    return (s == ST_PRESSED) || (s == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset loads both
// flops with RST_VAL so the first synchronized samples are a known idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes a raw pin, accepts a new level only after
// it holds for STABLE_CYCLES samples, and emits level, press/release strobes and a press count.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 24'd250000,
  parameter int unsigned CNT_WIDTH      = 24,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter int unsigned OUTPUT_SIZE    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn,
  output logic                   pressed,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic [OUTPUT_SIZE-1:0] press_count
);

  localparam logic [CNT_WIDTH-1:0] LAST_TICK = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic btn_sync;
  logic btn_n;

  // Reset value is the raw level of a released button for the chosen polarity.
  sync_2ff #(
    .RST_VAL (BTN_ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (btn_sync)
  );

  assign btn_n = btn_sync ^ BTN_ACTIVE_LOW;

  dbnc_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]   timer_q, timer_d;
  logic                   pressed_q, pressed_d;
  logic                   press_pulse_q, press_pulse_d;
  logic                   release_pulse_q, release_pulse_d;
  logic [OUTPUT_SIZE-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      count_q         <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_n) begin
          state_d = ST_PRESS_WAIT;
          timer_d = CNT_WIDTH'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_n) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == LAST_TICK) begin
          state_d = ST_PRESSED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_WIDTH'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_n) begin
          state_d = ST_RELEASE_WAIT;
          timer_d = CNT_WIDTH'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_n) begin
          state_d = ST_PRESSED;
          timer_d = '0;
        end else if (timer_q == LAST_TICK) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Outputs trail the state by one register; strobes mark edges of that registered level.
  always_comb begin
    pressed_d       = state_is_pressed(state_q);
    press_pulse_d   = pressed_d & ~pressed_q;
    release_pulse_d = ~pressed_d & pressed_q;
    count_d         = press_pulse_d ? count_q + OUTPUT_SIZE'(1) : count_q;
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-low and an active-high instance driven with
// complementary pins, checked by vector table, corner sequences and a sliding-window model.
module tb_button_debouncer;

  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_lo = 1'b1;
  logic       btn_hi = 1'b0;
  logic       p0, pp0, rp0, p1, pp1, rp1;
  logic [3:0] cnt0, cnt1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #2 clk = ~clk;

  button_debouncer #(
    .STABLE_CYCLES (S), .CNT_WIDTH (24), .BTN_ACTIVE_LOW (1'b1), .OUTPUT_SIZE (4)
  ) dut_lo (
    .clk (clk), .rst (rst), .btn (btn_lo),
    .pressed (p0), .press_pulse (pp0), .release_pulse (rp0), .press_count (cnt0)
  );

  button_debouncer #(
    .STABLE_CYCLES (S), .CNT_WIDTH (24), .BTN_ACTIVE_LOW (1'b0), .OUTPUT_SIZE (4)
  ) dut_hi (
    .clk (clk), .rst (rst), .btn (btn_hi),
    .pressed (p1), .press_pulse (pp1), .release_pulse (rp1), .press_count (cnt1)
  );

  // Reference: the accepted level flips once the S samples the FSM has seen
  // (raw samples two edges old, because of the synchronizer) all disagree with it.
  bit       hist [0:S];
  bit       m_fsm, m_pressed, m_pp, m_rp;
  int       m_cnt;

  task automatic model_edge(input bit r, input bit n);
    bit all_diff;
    bit new_pressed;
    if (r) begin
      for (int i = 0; i <= S; i++) hist[i] = 1'b0;
      m_fsm = 0; m_pressed = 0; m_pp = 0; m_rp = 0; m_cnt = 0;
    end else begin
      all_diff = 1'b1;
      for (int i = 1; i <= S; i++) if (hist[i] == m_fsm) all_diff = 1'b0;
      new_pressed = m_fsm;
      m_pp = new_pressed & ~m_pressed;
      m_rp = ~new_pressed & m_pressed;
      m_pressed = new_pressed;
      if (m_pp) m_cnt = (m_cnt + 1) % 16;
      if (all_diff) m_fsm = ~m_fsm;
      for (int i = S; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = n;
    end
  endtask

  function automatic int pack_lo();
    return {25'd0, p0, pp0, rp0, cnt0};
  endfunction

  function automatic int pack_hi();
    return {25'd0, p1, pp1, rp1, cnt1};
  endfunction

  function automatic int pack_exp(input bit p, input bit pp, input bit rp, input int c);
    return {25'd0, p, pp, rp, 4'(c)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock edge with the given inputs; btn is the active-low pin level.
  task automatic step(input logic r, input logic b);
    rst = r; btn_lo = b; btn_hi = ~b;
    @(posedge clk);
    model_edge(r, ~b);
    #1;
  endtask

  typedef struct {
    logic r;
    logic b;
    int   n;
    logic ep;
    logic epp;
    logic erp;
    int   ecnt;
  } vec_t;

  vec_t vecs [$];
  int   seen;
  int   pulses;
  int   hit;
  logic cur;

  initial begin
    // reset, clean press/release, bounce, hold-through-reset
    vecs.push_back('{1, 1, 2,  0, 0, 0, 0});
    vecs.push_back('{0, 1, 3,  0, 0, 0, 0});
    vecs.push_back('{0, 0, 10, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1,  1, 1, 0, 1});
    vecs.push_back('{0, 0, 1,  1, 0, 0, 1});
    vecs.push_back('{0, 0, 5,  1, 0, 0, 1});
    vecs.push_back('{0, 1, 10, 1, 0, 0, 1});
    vecs.push_back('{0, 1, 1,  0, 0, 1, 1});
    vecs.push_back('{0, 1, 1,  0, 0, 0, 1});
    vecs.push_back('{0, 0, 3,  0, 0, 0, 1});
    vecs.push_back('{0, 1, 3,  0, 0, 0, 1});
    vecs.push_back('{0, 0, 7,  0, 0, 0, 1});
    vecs.push_back('{0, 1, 12, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 12, 1, 0, 0, 2});
    vecs.push_back('{1, 0, 1,  0, 0, 0, 0});
    vecs.push_back('{0, 0, 10, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1,  1, 1, 0, 1});
    vecs.push_back('{0, 1, 11, 0, 0, 1, 1});

    #1;
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) step(vecs[i].r, vecs[i].b);
      chk($sformatf("vec%0d_lo", i), pack_lo(),
          pack_exp(vecs[i].ep, vecs[i].epp, vecs[i].erp, vecs[i].ecnt));
      chk($sformatf("vec%0d_hi", i), pack_hi(),
          pack_exp(vecs[i].ep, vecs[i].epp, vecs[i].erp, vecs[i].ecnt));
    end

    // Bounce: toggle every 3 cycles for 30 cycles, then settle released
    step(1, 1); step(0, 1); step(0, 1);
    pulses = 0;
    for (int seg = 0; seg < 10; seg++)
      for (int k = 0; k < 3; k++) begin
        step(0, (seg % 2 == 0) ? 1'b0 : 1'b1);
        pulses += pp0 + rp0 + pp1 + rp1 + p0 + p1;
      end
    for (int k = 0; k < 14; k++) begin
      step(0, 1);
      pulses += pp0 + rp0 + pp1 + rp1 + p0 + p1;
    end
    chk("bounce_activity", pulses, 0);
    chk("bounce_count", {28'd0, cnt0}, 0);

    // Wrap: 17 clean presses from reset
    step(1, 1); step(1, 1);
    for (int pr = 1; pr <= 17; pr++) begin
      pulses = 0;
      for (int k = 0; k < 12; k++) begin step(0, 0); pulses += pp0; end
      for (int k = 0; k < 12; k++) begin step(0, 1); pulses += pp0; end
      chk($sformatf("wrap_pulses%0d", pr), pulses, 1);
      if (pr == 15) chk("wrap_cnt15", {28'd0, cnt0}, 15);
      if (pr == 16) chk("wrap_cnt16", {28'd0, cnt1}, 0);
    end
    chk("wrap_cnt17_lo", {28'd0, cnt0}, 1);
    chk("wrap_cnt17_hi", {28'd0, cnt1}, 1);

    // Reset while PRESS_WAIT timer is 5, button kept held through and after reset
    step(1, 1); step(0, 1); step(0, 1);
    pulses = 0;
    for (int k = 0; k < 7; k++) begin step(0, 0); pulses += pp0 + pp1; end
    step(1, 0);
    chk("rstmid_no_pulse", pulses + pp0 + pp1, 0);
    chk("rstmid_outputs", pack_lo(), 0);
    hit = -1;
    for (int k = 1; k <= 20 && hit < 0; k++) begin
      step(0, 0);
      if (pp0) hit = k;
    end
    chk("rstmid_pulse_edge", hit, 11);
    chk("rstmid_count", {28'd0, cnt0}, 1);
    step(0, 0);
    chk("rstmid_pulse_width", {31'd0, pp0}, 0);

    // Randomized runs of random length, occasional reset
    step(1, 1);
    cur = 1'b1;
    seen = 0;
    while (seen < 4000) begin
      int len;
      cur = ~cur;
      len = $urandom_range(1, 14);
      for (int k = 0; k < len && seen < 4000; k++) begin
        step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, cur);
        seen++;
        chk("rand_lo", pack_lo(), pack_exp(m_pressed, m_pp, m_rp, m_cnt));
        chk("rand_hi", pack_hi(), pack_exp(m_pressed, m_pp, m_rp, m_cnt));
        chk("rand_excl", {31'd0, pp0 & rp0}, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
